// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with registered read data (1-cycle read latency); writes while full and reads while empty are dropped.
// Optional occupancy output `count` is enabled by defining SYNCHRONOUS_FIFO_COUNT_EN.
module synchronous_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
`ifdef SYNCHRONOUS_FIFO_COUNT_EN
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
`else
  output logic                    empty
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Extra MSB on each pointer distinguishes full from empty when addresses match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_INC;
        data_out <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

`ifdef SYNCHRONOUS_FIFO_COUNT_EN
  assign count = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Bench for synchronous_fifo: directed stimulus feeds a reference queue; a negedge monitor pops and compares.
module tb_synchronous_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef SYNCHRONOUS_FIFO_COUNT_EN
  logic [4:0]    count;
`endif

  synchronous_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
`ifdef SYNCHRONOUS_FIFO_COUNT_EN
    .empty    (empty),
    .count    (count)
`else
    .empty    (empty)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model_q[$];   // reference FIFO contents
  logic [DW-1:0] exp_q[$];     // read data expected on the next negedge
  logic [DW-1:0] last_exp = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a queued expectation means a read was accepted on the preceding edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      chk("rd_data", {24'h0, data_out}, {24'h0, e});
      last_exp = e;
    end else begin
      chk("dout_hold", {24'h0, data_out}, {24'h0, last_exp});
    end
    chk("empty", {31'h0, empty}, {31'h0, model_q.size() == 0});
    chk("full", {31'h0, full}, {31'h0, model_q.size() == DEPTH});
`ifdef SYNCHRONOUS_FIFO_COUNT_EN
    chk("count", {27'h0, count}, model_q.size());
`endif
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    logic wacc, racc;
    w_en    = w;
    r_en    = r;
    data_in = d;
    wacc = w && (model_q.size() < DEPTH);
    racc = r && (model_q.size() > 0);
    @(posedge clk);
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(d);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    cycle(1'b1, 1'b0, d);
  endtask

  task automatic rd();
    cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_exp = '0;
    #1;
    chk("arst_dout", {24'h0, data_out}, 32'h0);
    chk("arst_empty", {31'h0, empty}, 32'h1);
    chk("arst_full", {31'h0, full}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 8'h00);    // reset then idle

    wr(8'h24); wr(8'h81); wr(8'h09);
    rd(); rd(); rd();
    rd();                                   // read while empty is ignored

    for (int i = 0; i < 16; i++) wr(8'(i));
    wr(8'hAA);                              // dropped: fifo full
    for (int i = 0; i < 16; i++) rd();

    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    cycle(1'b1, 1'b1, 8'hBB);               // full: only the read is taken
    for (int i = 0; i < 15; i++) rd();

    cycle(1'b1, 1'b1, 8'h5A);               // empty: only the write is taken
    cycle(1'b1, 1'b1, 8'h3C);               // reads 0x5A, writes 0x3C
    rd();

    for (int i = 0; i < 60; i++) begin
      d = 8'($urandom);
      wr(d);
      rd();
    end

    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55);
    async_reset();
    rd(); rd(); rd();                       // nothing stored after reset
    wr(8'h77);
    rd();
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    chk("drain", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/synchronous_fifo.md
SYNCHRONOUS_FIFO -- requirements
Module: synchronous_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of storage entries; power of two, >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, width of each data word in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 w_en  input  1  write request, sampled at rising clk.
REQ-006 r_en  input  1  read request, sampled at rising clk.
REQ-007 data_in  input  DATA_WIDTH  write data, captured with an accepted write.
REQ-008 data_out  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when DEPTH entries are stored.
REQ-010 empty  output  1  high when no entries are stored.

Function
REQ-011 Storage SHALL be a DEPTH x DATA_WIDTH array addressed by write and read pointers of log2(DEPTH)+1 bits; the MSB is a wrap bit.
REQ-012 A write is accepted at a rising edge when w_en=1 and full=0: data_in stored at the write pointer; the write pointer increments.
REQ-013 A read is accepted at a rising edge when r_en=1 and empty=0: data_out loads the entry at the read pointer on that edge (1-cycle latency); the read pointer increments.
REQ-014 data_out SHALL hold its last value in every cycle without an accepted read.
REQ-015 empty SHALL be 1 when the pointers are equal, including the wrap bit.
REQ-016 full SHALL be 1 when the pointer address bits are equal and the wrap bits differ.
REQ-017 full and empty SHALL be combinational decodes of the registered pointers; they update in the cycle after the accepting edge.
REQ-018 A write while full SHALL be ignored: no storage change, no pointer change, no error output.
REQ-019 A read while empty SHALL be ignored: no pointer change; data_out holds.
REQ-020 Simultaneous w_en and r_en with 0 < occupancy < DEPTH: both SHALL be accepted; occupancy is unchanged.
REQ-021 Simultaneous w_en and r_en while empty: only the write is accepted. While full: only the read is accepted.
REQ-022 Pointers SHALL wrap modulo 2*DEPTH. Data order SHALL be strict first-in-first-out across any number of wraps.

Reset
REQ-023 rst_n=0 SHALL immediately, independent of clk, clear both pointers and set data_out=0, empty=1 and full=0.
REQ-024 Storage array contents SHALL NOT be reset. Reset asserted mid-operation discards all stored entries.
REQ-025 The first accepted operation is allowed at the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro SYNCHRONOUS_FIFO_COUNT_EN, when defined, SHALL add output count, width log2(DEPTH)+1, equal to (write pointer - read pointer) modulo 2*DEPTH. count is 0 at reset and ranges 0..DEPTH.
REQ-027 Without SYNCHRONOUS_FIFO_COUNT_EN, the count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset then idle: data_out=0x00, empty=1, full=0; count=0 when the macro is enabled.
REQ-029 Write 0x24, 0x81, 0x09, then read 3 times: data_out is 0x24, 0x81, 0x09 on successive read edges; empty=1 after the third read.
REQ-030 Write 16 words 0x00..0x0F: full=1 after the 16th write. A 17th write of 0xAA is ignored. 16 reads return 0x00..0x0F, and 0xAA never appears.
REQ-031 From empty, assert w_en=r_en=1 with data_in=0x5A: only the write is accepted and data_out holds. The next cycle with both asserted reads 0x5A and writes the next word.
REQ-032 Alternate-cycle writes and reads of 60 random words (pointer wrap exercised): every read matches write order; no overflow or underflow.
REQ-033 Assert rst_n=0 with 5 entries stored: empty=1, full=0 and data_out=0 asynchronously; subsequent reads are ignored until a new write.
